// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the D-stage instruction source and the
// hazard tracker.
//   IR_D              instruction currently held in D (driven by the pipeline)
//   stall             freeze PC/D, bubble E (driven by the tracker)
//   A3_E/M/W          destination register per stage, 0 = no write
//   RWE_E/M/W         register-write enable per stage
//   Tnew_E/M          cycles until the stage's result exists
//   Ready_E/M         Tnew_X == 0; forwarding from X is legal only when set
interface hazard_ctrl_if;
  logic [31:0] IR_D;
  logic        stall;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic        RWE_E, RWE_M, RWE_W;
  logic [1:0]  Tnew_E, Tnew_M;
  logic        Ready_E, Ready_M;

  modport master (
    output IR_D,
    input  stall, A3_E, A3_M, A3_W, RWE_E, RWE_M, RWE_W,
    input  Tnew_E, Tnew_M, Ready_E, Ready_M
  );

  modport slave (
    input  IR_D,
    output stall, A3_E, A3_M, A3_W, RWE_E, RWE_M, RWE_W,
    output Tnew_E, Tnew_M, Ready_E, Ready_M
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard tracker for the 5-stage MIPS core.
// Decodes the D-stage instruction into a {A3, RWE, Tnew} record, carries it
// through E, M and W, and raises a combinational stall whenever a D operand
// cannot be forwarded in time.
//   clk    pipeline clock, rising edge
//   reset  synchronous, active-high; clears the E/M/W records
//   bus    hazard_ctrl_if.slave (IR_D in; stall and per-stage status out)
module hazard_ctrl (
  input logic           clk,
  input logic           reset,
  hazard_ctrl_if.slave  bus
);

  logic [31:0] ir;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic        shamt_unused;

  assign ir           = bus.IR_D;
  assign op           = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign funct        = ir[5:0];
  assign shamt_unused = ^ir[10:6];

  // D-stage decode: which operands are read and when, what is written and
  // when its value appears.
  logic       rs_used, rt_used;
  logic [1:0] tuse_rs, tuse_rt;
  logic [4:0] a3_raw;
  logic [1:0] tnew_raw;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    rs_used  = 1'b0;
    rt_used  = 1'b0;
    tuse_rs  = 2'd0;
    tuse_rt  = 2'd0;
    a3_raw   = 5'd0;
    tnew_raw = 2'd0;
    case (op)
      6'h00: begin
        case (funct)
          6'h21, 6'h23: begin // addu, subu
            rs_used  = 1'b1;
            rt_used  = 1'b1;
            tuse_rs  = 2'd1;
            tuse_rt  = 2'd1;
            a3_raw   = rd;
            tnew_raw = 2'd1;
          end
          6'h08: begin // jr
            rs_used = 1'b1;
            tuse_rs = 2'd0;
          end
          default: ;
        endcase
      end
      6'h0D: begin // ori
        rs_used  = 1'b1;
        tuse_rs  = 2'd1;
        a3_raw   = rt;
        tnew_raw = 2'd1;
      end
      6'h0F: begin // lui
        a3_raw   = rt;
        tnew_raw = 2'd1;
      end
      6'h23: begin // lw
        rs_used  = 1'b1;
        tuse_rs  = 2'd1;
        a3_raw   = rt;
        tnew_raw = 2'd2;
      end
      6'h2B: begin // sw: store data is only needed in M
        rs_used = 1'b1;
        rt_used = 1'b1;
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      6'h04: begin // beq
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      6'h03: begin // jal: link value is known at decode
        a3_raw   = 5'd31;
        tnew_raw = 2'd0;
      end
      default: ; // j and unknown encodings read and write nothing
    endcase
  end

  // Writes to $0 are dropped here so the record can never match an operand.
  logic       rwe_d;
  logic [1:0] tnew_d;
  assign rwe_d  = (a3_raw != 5'd0);
  assign tnew_d = rwe_d ? tnew_raw : 2'd0;

  // Stage records.
  logic [4:0] e_a3, m_a3, w_a3;
  logic       e_rwe, m_rwe, w_rwe;
  logic [1:0] e_tnew, m_tnew;

  function automatic logic hit(input logic used, input logic [4:0] src,
                               input logic [1:0] tuse, input logic rwe,
                               input logic [4:0] a3, input logic [1:0] tnew);
    return used && (src != 5'd0) && rwe && (src == a3) && (tnew > tuse);
  endfunction

  logic stall;
  assign stall = hit(rs_used, rs, tuse_rs, e_rwe, e_a3, e_tnew)
               | hit(rs_used, rs, tuse_rs, m_rwe, m_a3, m_tnew)
               | hit(rt_used, rt, tuse_rt, e_rwe, e_a3, e_tnew)
               | hit(rt_used, rt, tuse_rt, m_rwe, m_a3, m_tnew);

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value, modelling a true shift of the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3   <= 5'd0;
      e_rwe  <= 1'b0;
      e_tnew <= 2'd0;
      m_a3   <= 5'd0;
      m_rwe  <= 1'b0;
      m_tnew <= 2'd0;
      w_a3   <= 5'd0;
      w_rwe  <= 1'b0;
    end else begin
      if (stall) begin
        e_a3   <= 5'd0;
        e_rwe  <= 1'b0;
        e_tnew <= 2'd0;
      end else begin
        e_a3   <= a3_raw;
        e_rwe  <= rwe_d;
        e_tnew <= tnew_d;
      end
      m_a3   <= e_a3;
      m_rwe  <= e_rwe;
      m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
      w_a3   <= m_a3;
      w_rwe  <= m_rwe;
    end
  end

  assign bus.stall   = stall;
  assign bus.A3_E    = e_a3;
  assign bus.A3_M    = m_a3;
  assign bus.A3_W    = w_a3;
  assign bus.RWE_E   = e_rwe;
  assign bus.RWE_M   = m_rwe;
  assign bus.RWE_W   = w_rwe;
  assign bus.Tnew_E  = e_tnew;
  assign bus.Tnew_M  = m_tnew;
  assign bus.Ready_E = (e_tnew == 2'd0);
  assign bus.Ready_M = (m_tnew == 2'd0);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed, table-driven bench for hazard_ctrl. Each table
// row gives the instruction held in D for one cycle and the outputs expected
// in that cycle; hand-written sequences cover reset during a stall and a
// register written by both E and M.
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic        stall;
    logic [4:0]  a3_e;
    logic        rwe_e;
    logic [1:0]  tnew_e;
    logic [4:0]  a3_m;
    logic        rwe_m;
    logic [1:0]  tnew_m;
    logic [4:0]  a3_w;
    logic        rwe_w;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] ir, input logic st,
                              input logic [4:0] ae, input logic re, input logic [1:0] te,
                              input logic [4:0] am, input logic rm, input logic [1:0] tm,
                              input logic [4:0] aw, input logic rw);
    vec_t v;
    v.ir = ir; v.stall = st;
    v.a3_e = ae; v.rwe_e = re; v.tnew_e = te;
    v.a3_m = am; v.rwe_m = rm; v.tnew_m = tm;
    v.a3_w = aw; v.rwe_w = rw;
    return v;
  endfunction

  task automatic check_row(input string tag, input vec_t v);
    check({tag, " stall"},   32'(bus.stall),   32'(v.stall));
    check({tag, " A3_E"},    32'(bus.A3_E),    32'(v.a3_e));
    check({tag, " RWE_E"},   32'(bus.RWE_E),   32'(v.rwe_e));
    check({tag, " Tnew_E"},  32'(bus.Tnew_E),  32'(v.tnew_e));
    check({tag, " Ready_E"}, 32'(bus.Ready_E), 32'(v.tnew_e == 2'd0));
    check({tag, " A3_M"},    32'(bus.A3_M),    32'(v.a3_m));
    check({tag, " RWE_M"},   32'(bus.RWE_M),   32'(v.rwe_m));
    check({tag, " Tnew_M"},  32'(bus.Tnew_M),  32'(v.tnew_m));
    check({tag, " Ready_M"}, 32'(bus.Ready_M), 32'(v.tnew_m == 2'd0));
    check({tag, " A3_W"},    32'(bus.A3_W),    32'(v.a3_w));
    check({tag, " RWE_W"},   32'(bus.RWE_W),   32'(v.rwe_w));
  endtask

  // Apply an instruction in D half a cycle before the next rising edge.
  task automatic drive(input logic [31:0] ir, input logic rst);
    @(negedge clk);
    bus.IR_D = ir;
    reset    = rst;
    #1;
  endtask

  localparam int NV = 22;
  vec_t vecs [NV];

  logic [31:0] nop, lw1, lw2, addu312, beq12, addu456, jr4, sw12, ori0;
  logic [31:0] addu300, jal_i, jr31, subu567, beq50, junk, lui2, beq20;

  initial begin
    nop     = 32'h0;
    lw1     = i_type(6'h23, 5'd0, 5'd1, 16'd0);
    lw2     = i_type(6'h23, 5'd0, 5'd2, 16'd0);
    addu312 = r_type(5'd1, 5'd2, 5'd3, 6'h21);
    beq12   = i_type(6'h04, 5'd1, 5'd2, 16'd0);
    addu456 = r_type(5'd5, 5'd6, 5'd4, 6'h21);
    jr4     = r_type(5'd4, 5'd0, 5'd0, 6'h08);
    sw12    = i_type(6'h2B, 5'd2, 5'd1, 16'd0);
    ori0    = i_type(6'h0D, 5'd0, 5'd0, 16'd5);
    addu300 = r_type(5'd0, 5'd0, 5'd3, 6'h21);
    jal_i   = {6'h03, 26'd0};
    jr31    = r_type(5'd31, 5'd0, 5'd0, 6'h08);
    subu567 = r_type(5'd6, 5'd7, 5'd5, 6'h23);
    beq50   = i_type(6'h04, 5'd5, 5'd0, 16'd0);
    junk    = 32'hFC21FFFF;
    lui2    = i_type(6'h0F, 5'd0, 5'd2, 16'h1234);
    beq20   = i_type(6'h04, 5'd2, 5'd0, 16'd0);

    //               ir       st  E:a3 rwe tn   M:a3 rwe tn   W:a3 rwe
    // lw -> addu: one stall cycle, bubble in E, lw in M not yet ready
    vecs[0]  = mk(lw1,     0,  0, 0, 0,  0, 0, 0,  0, 0);
    vecs[1]  = mk(addu312, 1,  1, 1, 2,  0, 0, 0,  0, 0);
    vecs[2]  = mk(addu312, 0,  0, 0, 0,  1, 1, 1,  0, 0);
    vecs[3]  = mk(nop,     0,  3, 1, 1,  0, 0, 0,  1, 1);
    // lw -> beq: two stall cycles
    vecs[4]  = mk(lw1,     0,  0, 0, 0,  3, 1, 0,  0, 0);
    vecs[5]  = mk(beq12,   1,  1, 1, 2,  0, 0, 0,  3, 1);
    vecs[6]  = mk(beq12,   1,  0, 0, 0,  1, 1, 1,  0, 0);
    vecs[7]  = mk(beq12,   0,  0, 0, 0,  0, 0, 0,  1, 1);
    // addu -> jr: one stall cycle, then result ready in M
    vecs[8]  = mk(addu456, 0,  0, 0, 0,  0, 0, 0,  0, 0);
    vecs[9]  = mk(jr4,     1,  4, 1, 1,  0, 0, 0,  0, 0);
    vecs[10] = mk(jr4,     0,  0, 0, 0,  4, 1, 0,  0, 0);
    // lw -> sw using the loaded value as store data: no stall
    vecs[11] = mk(lw1,     0,  0, 0, 0,  0, 0, 0,  4, 1);
    vecs[12] = mk(sw12,    0,  1, 1, 2,  0, 0, 0,  0, 0);
    // write to $0 is discarded, so a $0 reader never stalls
    vecs[13] = mk(ori0,    0,  0, 0, 0,  1, 1, 1,  0, 0);
    vecs[14] = mk(addu300, 0,  0, 0, 0,  0, 0, 0,  1, 1);
    // jal -> jr $31: link value ready immediately
    vecs[15] = mk(jal_i,   0,  3, 1, 1,  0, 0, 0,  0, 0);
    vecs[16] = mk(jr31,    0, 31, 1, 0,  3, 1, 0,  0, 0);
    // subu -> beq
    vecs[17] = mk(subu567, 0,  0, 0, 0, 31, 1, 0,  3, 1);
    vecs[18] = mk(beq50,   1,  5, 1, 1,  0, 0, 0, 31, 1);
    vecs[19] = mk(beq50,   0,  0, 0, 0,  5, 1, 0,  0, 0);
    // unknown encoding: no write, no reads
    vecs[20] = mk(junk,    0,  0, 0, 0,  0, 0, 0,  5, 1);
    vecs[21] = mk(nop,     0,  0, 0, 0,  0, 0, 0,  0, 0);

    bus.IR_D = 32'h0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    drive(nop, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ir, 1'b0);
      check_row($sformatf("r%0d", i), vecs[i]);
    end

    // Reset asserted during the first stall cycle of lw -> beq.
    drive(lw1, 1'b0);
    drive(beq12, 1'b0);
    check("rst_seq stall before", 32'(bus.stall), 32'd1);
    drive(beq12, 1'b1);
    drive(beq12, 1'b0);
    check_row("rst_seq after", mk(beq12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(nop, 1'b0);
    check("rst_seq beq passed stall", 32'(bus.stall), 32'd0);

    // Same register written by both E (lui) and M (lw), read by beq.
    drive(lw2, 1'b0);
    drive(lui2, 1'b0);
    drive(beq20, 1'b0);
    check_row("dual hit", mk(beq20, 1, 2, 1, 1, 2, 1, 1, 0, 0));
    drive(beq20, 1'b0);
    check_row("dual release", mk(beq20, 0, 0, 0, 0, 2, 1, 0, 2, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard tracker for the 5-stage MIPS core. It decodes the instruction in D to find its destination register and result-ready time, and carries that record down through E, M and W in step with the datapath. It asserts `stall` whenever a D-stage operand cannot be satisfied by forwarding in time. It also publishes per-stage destination, write-enable and readiness, which the forwarding selector consumes.

## Interface
Parameters: none.

- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; clears all tracked state.
- `IR_D` input 32: instruction currently in the D stage.
- `stall` output 1: combinational; freezes the PC and the D register, and clears the E register.
- `A3_E`, `A3_M`, `A3_W` output 5 each: destination register held by each stage; 0 means no write.
- `RWE_E`, `RWE_M`, `RWE_W` output 1 each: register-write enable for each stage.
- `Tnew_E`, `Tnew_M` output 2 each: cycles until the stage's result exists. The W stage is always ready.
- `Ready_E`, `Ready_M` output 1 each: `Tnew_X == 0`. The forwarding selector may only select stage X when its `Ready_X` is 1.

## Operation
Decode of `IR_D` is combinational. Fields: `op`=31:26, `rs`=25:21, `rt`=20:16, `rd`=15:11, `funct`=5:0.

| Instruction | Match | Tuse_rs | Tuse_rt | A3 | Tnew on entering E |
|---|---|---|---|---|---|
| addu | op=0, funct=0x21 | 1 | 1 | rd | 1 |
| subu | op=0, funct=0x23 | 1 | 1 | rd | 1 |
| jr | op=0, funct=0x08 | 0 | none | none | — |
| ori | 0x0D | 1 | none | rt | 1 |
| lui | 0x0F | none | none | rt | 1 |
| lw | 0x23 | 1 | none | rt | 2 |
| sw | 0x2B | 1 | 2 | none | — |
| beq | 0x04 | 0 | 0 | none | — |
| j | 0x02 | none | none | none | — |
| jal | 0x03 | none | none | 31 | 0 |

- "none" means that operand is not read (no stall contribution) or no register is written.
- Any other encoding, including 0x00000000: no reads, no write.
- If the decoded A3 is 0, the record is forced to RWE=0, A3=0, Tnew=0.

Stage record `{A3, RWE, Tnew}` advances every edge:
- E ← D-decode when `stall`=0. E ← bubble `{0,0,0}` when `stall`=1.
- M ← E, with `Tnew = sat_dec(Tnew_E)`.
- W ← M, with Tnew dropped.
- `sat_dec(x) = (x==0) ? 0 : x-1`. Width is 2 bits; the value never wraps below 0.
- M and W advance even while `stall`=1; only the D→E transfer is blocked.

Stall rule:
- For each read operand `src` ∈ {rs, rt} with Tuse `u`, and each stage X ∈ {E, M}: stall if `src != 0`, `RWE_X`, `src == A3_X`, and `Tnew_X > u`.
- `stall` is the OR over all operand/stage combinations.
- W never causes a stall.
- Stall is recomputed every cycle from the registered state. There is no stall counter; multi-cycle stalls arise naturally as `Tnew` decrements.

Boundary cases:
- Both operands hit different stages: OR of conditions; single `stall`.
- Same register written by both E and M: each stage is checked independently. The youngest (E) dominates in practice.
- `reset`=1: E, M and W records become `{0,0,0}` at the edge regardless of `stall`. `stall` then depends only on the cleared state, so it reads 0 in the cycle after reset.
- A3 of 0 never matches. Writes to $0 are discarded at decode.

## Timing
- Reset values: `A3_*`=0, `RWE_*`=0, `Tnew_*`=0, `Ready_*`=1, `stall`=0 (with a cleared pipeline).
- Decode→E latency is 1 edge. The W record is valid 3 edges after D acceptance.
- `stall`, `Ready_*` and `Tnew_*` are valid in the same cycle from the current state. There is no registered output delay on `stall`.
- Per-edge stage counts:
  - lw: Tnew_E=2, then Tnew_M=1, then W.
  - ALU op: Tnew_E=1, then Tnew_M=0.

## Test plan
- **lw → addu:** `lw $1,0($0)` followed by `addu $3,$1,$2`. Expect `stall`=1 for exactly 1 cycle, with a bubble in E (`RWE_E`=0). addu then enters E while lw is in M with `Tnew_M`=1 and `Ready_M`=0.
- **lw → beq:** `lw $1` followed by `beq $1,$2`. Expect `stall`=1 for 2 consecutive cycles, then 0 once lw is in W.
- **ALU → branch:** `addu $4,$5,$6` followed by `jr $4`. Expect `stall`=1 for 1 cycle. Then `A3_M`=4, `Tnew_M`=0, `Ready_M`=1.
- **No-stall cases:**
  - `lw $1` followed by `sw $1,0($2)` (rt Tuse=2): `stall` stays 0.
  - `ori $0,$0,5` followed by `addu $3,$0,$0`: `stall` stays 0, and `RWE_E`=0 after ori.
- **jal:** `jal` followed by `jr $31`. Expect `A3_E`=31, `Tnew_E`=0, and `stall`=0.
- **Reset during stall:** assert `reset` during the first stall cycle of lw→beq. At the next edge, all `A3_*`=0 and `RWE_*`=0, and `stall`=0 while beq is held in D.
